iot_event_arbiter: RTL and testbench
====================================

Name: iot_event_arbiter

Overview:
- Sits between N IoT device request ports and the active-device monitor counter, which has change/on_off inputs.
- Accepts join/leave requests from each device through a valid/ready handshake.
- Filters redundant events, then serialises the rest round-robin into single-cycle change pulses with on_off set (1 = count up, 0 = count down).
- Keeps a per-device active mask and a shadow count that matches the monitor's count.

Parameters:
- N_DEV, 4, number of device request ports (2..16)
- CNT_W, 8, width of shadow count; requires N_DEV < 2^CNT_W

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req_valid  in  N_DEV  per-device request valid
- req_dir  in  N_DEV  per-device direction: 1 = join, 0 = leave
- req_ready  out  N_DEV  per-device ready; equals ~pend[i]
- pause  in  1  1 = hold all issuing; capture continues
- change  out  1  one-cycle pulse to monitor; registered
- on_off  out  1  direction for monitor; registered; valid when change=1
- grant_id  out  clog2(N_DEV)  device index of current issue slot
- dup_err  out  1  one-cycle pulse when a redundant request is discarded
- active_mask  out  N_DEV  1 = device currently counted active
- active_cnt  out  CNT_W  popcount of active_mask; registered
- busy  out  1  1 when any pend[i] is set or the FSM is not IDLE

Behaviour:
- Reset (rst=0, async):
  - pend=0, pend_dir=0, rr_ptr=0.
  - change=0, on_off=0, grant_id=0, dup_err=0.
  - active_mask=0, active_cnt=0.
  - FSM=IDLE.
- Capture:
  - At each rising edge, for each i with req_valid[i] & req_ready[i]: pend[i]<=1, pend_dir[i]<=req_dir[i].
  - A device holding req_valid while not ready is not captured; it waits.
  - One outstanding request per device.
- FSM:
  - IDLE: pend==0 → stay. Any pend & ~pause → ISSUE. Any pend & pause → PAUSED.
  - ISSUE: each cycle, select the first pend[j] searching j = rr_ptr, rr_ptr+1, ... mod N_DEV. Clear pend[j]; rr_ptr <= (j+1) mod N_DEV; grant_id <= j.
    - pend_dir[j]=1 and active_mask[j]=0: change<=1, on_off<=1, active_mask[j]<=1, active_cnt+1.
    - pend_dir[j]=0 and active_mask[j]=1: change<=1, on_off<=0, active_mask[j]<=0, active_cnt-1.
    - Otherwise (redundant join or leave): change<=0, dup_err<=1. The slot is still consumed and rr_ptr still advances.
    - Next state: no other pend remaining → IDLE; pause=1 → PAUSED; else stay in ISSUE.
  - PAUSED: no issue. pause=0 & any pend → ISSUE. pause=0 & no pend → IDLE.
- Latency: request accepted at edge k, uncontended → change high in cycle k+1..k+2 (registered at edge k+1). The monitor updates at edge k+2.
- Throughput: at most one event per cycle.
- Capture and issue on the same edge:
  - For a device's own slot: clear takes effect first; the device is re-ready the next cycle.
  - A request captured at edge k is never issued at edge k.
- active_cnt never wraps: at most N_DEV bits can be set, so it stays in range by construction. No saturation logic is needed beyond this.
- change, dup_err: each is a single-cycle pulse per issue slot. They are never both 1 in the same cycle.
- Reset mid-operation: all pending requests are dropped and active_mask is cleared. Reset the monitor concurrently so its count matches.

Test Plan:
- Reset:
  - Assert rst=0 mid-run with pend=4'b1011 → all outputs 0, req_ready=4'b1111.
  - Release, idle 3 cycles → change stays 0, busy=0.
- Single join: dev2 valid, dir=1 at edge k → change=1, on_off=1, grant_id=2 in cycle after k+1; active_mask=4'b0100, active_cnt=1.
- Simultaneous joins: all 4 devices join on the same edge with rr_ptr=0 → grants 0,1,2,3 on 4 consecutive cycles, 4 change pulses, active_cnt=4, then IDLE.
- Redundant requests:
  - dev1 joins twice → second slot gives dup_err=1, change=0, active_cnt unchanged.
  - Leave from inactive dev3 → dup_err=1.
- Pause: pause=1 with dev0 and dev1 pending → no change for 5 cycles, busy=1, req_ready=4'b1100. Release → grants 0 then 1.
- Fairness: dev0 re-requests continuously while dev3 requests → grants alternate 0,3,0,3. dev3 is granted within N_DEV cycles.

Source files
------------

// File: rtl/iot_event_arbiter.sv
// -----------------------------------------------------------------------------
// iot_event_arbiter
//
// Collects join/leave requests from N_DEV IoT devices and turns them into a
// serial stream of single-cycle change pulses for the active-device monitor
// counter. Redundant requests are dropped: a join from a device that is
// already active, or a leave from a device that is not active. They are
// reported on dup_err. Pending requests are served round-robin, so a device
// that re-requests continuously cannot starve the others.
//
// Handshake: a request on device i transfers on a rising edge where
// req_valid[i] and req_ready[i] are both 1. req_ready[i] is low while that
// device already has a request pending, so each device has at most one
// request outstanding. A device that holds req_valid while not ready simply
// waits, and its req_dir must stay stable until the transfer.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   req_valid    per-device request valid
//   req_dir      per-device direction (1 = join, 0 = leave)
//   req_ready    per-device ready (= no request pending for that device)
//   pause        1 = issue nothing; request capture keeps running
//   change       registered one-cycle pulse to the monitor
//   on_off       registered direction for the monitor; valid while change=1
//   grant_id     device index of the most recent issue slot
//   dup_err      registered one-cycle pulse when a redundant request is dropped
//   active_mask  1 = device currently counted as active
//   active_cnt   popcount of active_mask (registered shadow of the monitor)
//   busy         a request is pending or the FSM is not IDLE
//   dbg_state    FSM state for debug (0 = IDLE, 1 = ISSUE, 2 = PAUSED)
// -----------------------------------------------------------------------------
module iot_event_arbiter #(
  parameter int N_DEV = 4,
  parameter int CNT_W = 8,
  localparam int ID_W = $clog2(N_DEV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] req_valid,
  input  logic [N_DEV-1:0] req_dir,
  output logic [N_DEV-1:0] req_ready,
  input  logic             pause,
  output logic             change,
  output logic             on_off,
  output logic [ID_W-1:0]  grant_id,
  output logic             dup_err,
  output logic [N_DEV-1:0] active_mask,
  output logic [CNT_W-1:0] active_cnt,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_DEV-1:0] pend_q, pend_dir_q;
  logic [ID_W-1:0]  rr_q;

  // Round-robin search: the first pending device at or after rr_q.
  logic            found;
  logic [ID_W-1:0] sel;
  logic [ID_W-1:0] cand;
  int              idx;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    idx   = 0;
    for (int k = 0; k < N_DEV; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_DEV) idx = idx - N_DEV;
      cand = ID_W'(idx);
      if (!found && pend_q[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // An issue slot happens in IDLE or ISSUE when something is pending and
  // pause is low. Letting IDLE issue directly gives the one-edge latency
  // from capture to the change pulse. PAUSED always spends one cycle
  // returning to ISSUE before it issues again.
  logic             issue_en;
  logic             do_join, do_leave;
  logic [N_DEV-1:0] clr_vec, capture, remaining, pend_d;
  logic [ID_W-1:0]  rr_next;

  always_comb begin
    issue_en = found && !pause && (state_q != PAUSED);
    do_join  = pend_dir_q[sel] && !active_mask[sel];
    do_leave = !pend_dir_q[sel] && active_mask[sel];
    clr_vec  = '0;
    if (issue_en) clr_vec[sel] = 1'b1;
    // Only ready devices capture, so a device's own clear and a new capture
    // of that device never fall on the same edge.
    capture   = req_valid & ~pend_q;
    remaining = pend_q & ~clr_vec;
    pend_d    = remaining | capture;
    if (int'(sel) == N_DEV - 1) rr_next = '0;
    else                        rr_next = sel + ID_W'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          if (pause)           state_d = PAUSED;
          else if (|remaining) state_d = ISSUE;
          else                 state_d = IDLE;
        end
      end
      ISSUE: begin
        if (!(|remaining)) state_d = IDLE;
        else if (pause)    state_d = PAUSED;
        else               state_d = ISSUE;
      end
      PAUSED: begin
        if (!pause) state_d = (|pend_q) ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      pend_dir_q  <= '0;
      rr_q        <= '0;
      change      <= 1'b0;
      on_off      <= 1'b0;
      grant_id    <= '0;
      dup_err     <= 1'b0;
      active_mask <= '0;
      active_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_dir_q <= (pend_dir_q & ~capture) | (req_dir & capture);
      change     <= 1'b0;
      dup_err    <= 1'b0;
      if (issue_en) begin
        rr_q     <= rr_next;
        grant_id <= sel;
        if (do_join) begin
          change           <= 1'b1;
          on_off           <= 1'b1;
          active_mask[sel] <= 1'b1;
          active_cnt       <= active_cnt + CNT_W'(1);
        end else if (do_leave) begin
          change           <= 1'b1;
          on_off           <= 1'b0;
          active_mask[sel] <= 1'b0;
          active_cnt       <= active_cnt - CNT_W'(1);
        end else begin
          dup_err <= 1'b1;
        end
      end
    end
  end

  assign req_ready = ~pend_q;
  assign busy      = (|pend_q) || (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_iot_event_arbiter.sv
module tb_iot_event_arbiter;

  localparam int N_DEV = 4;
  localparam int CNT_W = 8;
  localparam int ID_W  = 2;
  localparam int EV_W  = 3 + ID_W;

  logic             clk;
  logic             rst;
  logic [N_DEV-1:0] req_valid;
  logic [N_DEV-1:0] req_dir;
  logic [N_DEV-1:0] req_ready;
  logic             pause;
  logic             change;
  logic             on_off;
  logic [ID_W-1:0]  grant_id;
  logic             dup_err;
  logic [N_DEV-1:0] active_mask;
  logic [CNT_W-1:0] active_cnt;
  logic             busy;
  logic [1:0]       dbg_state;

  iot_event_arbiter #(.N_DEV(N_DEV), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_dir(req_dir),
    .req_ready(req_ready), .pause(pause), .change(change), .on_off(on_off),
    .grant_id(grant_id), .dup_err(dup_err), .active_mask(active_mask),
    .active_cnt(active_cnt), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries are {dup_err, change, on_off, grant_id}; on_off is
  // recorded as 0 for dropped (dup) slots.
  logic [EV_W-1:0] exp_q[$];

  // reference model of the active set and the round-robin pointer
  logic [N_DEV-1:0] model_mask;
  int               model_rr;

  typedef struct {
    logic [N_DEV-1:0] valid;
    logic [N_DEV-1:0] dir;
    logic [N_DEV-1:0] exp_mask;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_issue(input int id, input logic dir);
    logic [EV_W-1:0] ev;
    if (dir && !model_mask[id]) begin
      ev = {1'b0, 1'b1, 1'b1, ID_W'(id)};
      model_mask[id] = 1'b1;
    end else if (!dir && model_mask[id]) begin
      ev = {1'b0, 1'b1, 1'b0, ID_W'(id)};
      model_mask[id] = 1'b0;
    end else begin
      ev = {1'b1, 1'b0, 1'b0, ID_W'(id)};
    end
    exp_q.push_back(ev);
    model_rr = (id + 1) % N_DEV;
  endtask

  // a batch of simultaneous requests is served in round-robin order
  task automatic model_batch(input logic [N_DEV-1:0] v, input logic [N_DEV-1:0] d);
    int start;
    int id;
    start = model_rr;
    for (int k = 0; k < N_DEV; k++) begin
      id = (start + k) % N_DEV;
      if (v[id]) model_issue(id, d[id]);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(posedge clk); #2;
    while ((busy || exp_q.size() != 0) && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 60) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: busy=%0b pending_events=%0d expected idle", busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic drive_batch(input logic [N_DEV-1:0] v, input logic [N_DEV-1:0] d);
    @(posedge clk); #1;
    model_batch(v, d);
    req_valid = v;
    req_dir   = d;
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
  endtask

  // monitor: every issue slot is compared against the expected queue
  always @(negedge clk) begin
    logic [EV_W-1:0] act;
    logic [EV_W-1:0] exp;
    if (rst && (change || dup_err)) begin
      act = {dup_err, change, change ? on_off : 1'b0, grant_id};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: got {dup,chg,dir,id}=%b expected none", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          failures++;
          $display("FAIL issue_event: got {dup,chg,dir,id}=%b expected %b", act, exp);
        end
      end
    end
  end

  initial begin
    vecs[0] = '{4'b1111, 4'b1111, 4'b1111, 8'd4}; // simultaneous joins
    vecs[1] = '{4'b0010, 4'b0000, 4'b1101, 8'd3}; // dev1 leave
    vecs[2] = '{4'b0010, 4'b0010, 4'b1111, 8'd4}; // dev1 join
    vecs[3] = '{4'b0010, 4'b0010, 4'b1111, 8'd4}; // dev1 join again: dup
    vecs[4] = '{4'b1001, 4'b0000, 4'b0110, 8'd2}; // dev0, dev3 leave
    vecs[5] = '{4'b1000, 4'b0000, 4'b0110, 8'd2}; // leave inactive dev3: dup
    vecs[6] = '{4'b0100, 4'b0000, 4'b0010, 8'd1};
    vecs[7] = '{4'b0101, 4'b0101, 4'b0111, 8'd3};
    vecs[8] = '{4'b1110, 4'b0000, 4'b0001, 8'd1}; // dev3 dup among leaves
    vecs[9] = '{4'b1111, 4'b0000, 4'b0000, 8'd0};

    rst        = 1'b0;
    req_valid  = '0;
    req_dir    = '0;
    pause      = 1'b0;
    model_mask = '0;
    model_rr   = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_change", 32'(change), 32'd0);
    check("reset_ready", 32'(req_ready), 32'hF);
    check("reset_cnt", 32'(active_cnt), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // table-driven batches
    for (int i = 0; i < 10; i++) begin
      drive_batch(vecs[i].valid, vecs[i].dir);
      check($sformatf("vec%0d_mask", i), 32'(active_mask), 32'(vecs[i].exp_mask));
      check($sformatf("vec%0d_cnt", i), 32'(active_cnt), 32'(vecs[i].exp_cnt));
    end

    // single join of dev2: change registered one edge after capture
    @(posedge clk); #1;
    model_batch(4'b0100, 4'b0100);
    req_valid = 4'b0100;
    req_dir   = 4'b0100;
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("join_capture_change", 32'(change), 32'd0);
    check("join_capture_ready", 32'(req_ready), 32'b1011);
    check("join_capture_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("join_change", 32'(change), 32'd1);
    check("join_on_off", 32'(on_off), 32'd1);
    check("join_grant", 32'(grant_id), 32'd2);
    check("join_mask", 32'(active_mask), 32'b0100);
    check("join_cnt", 32'(active_cnt), 32'd1);
    wait_idle();

    // pause with dev0 and dev1 pending
    @(posedge clk); #1;
    pause     = 1'b1;
    req_valid = 4'b0011;
    req_dir   = 4'b0011;
    @(posedge clk); #1;
    req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("pause_change", 32'(change), 32'd0);
      check("pause_busy", 32'(busy), 32'd1);
      check("pause_ready", 32'(req_ready), 32'b1100);
    end
    model_batch(4'b0011, 4'b0011);
    @(posedge clk); #1;
    pause = 1'b0;
    wait_idle();
    check("pause_mask", 32'(active_mask), 32'b0111);
    check("pause_cnt", 32'(active_cnt), 32'd3);

    // fairness: dev0 (leave) and dev3 (join) hold valid for 6 edges
    begin
      int first;
      int other;
      first = ((N_DEV + 3 - model_rr) % N_DEV < (N_DEV - model_rr) % N_DEV) ? 3 : 0;
      other = (first == 3) ? 0 : 3;
      @(posedge clk); #1;
      for (int s = 0; s < 6; s++) begin
        if (s % 2 == 0) model_issue(first, first == 3);
        else            model_issue(other, other == 3);
      end
      req_valid = 4'b1001;
      req_dir   = 4'b1000;
      repeat (6) @(posedge clk);
      #1;
      req_valid = '0;
      wait_idle();
      check("fair_mask", 32'(active_mask), 32'b1110);
      check("fair_cnt", 32'(active_cnt), 32'd3);
    end

    // reset in the middle of operation with pend = 1011
    @(posedge clk); #1;
    pause     = 1'b1;
    req_valid = 4'b1011;
    req_dir   = 4'b1111;
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("midrst_pre_ready", 32'(req_ready), 32'b0100);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_ready", 32'(req_ready), 32'hF);
    check("midrst_change", 32'(change), 32'd0);
    check("midrst_on_off", 32'(on_off), 32'd0);
    check("midrst_grant", 32'(grant_id), 32'd0);
    check("midrst_dup", 32'(dup_err), 32'd0);
    check("midrst_mask", 32'(active_mask), 32'd0);
    check("midrst_cnt", 32'(active_cnt), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    model_mask = '0;
    model_rr   = 0;
    pause      = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_change", 32'(change), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end

    // all expected events must have been seen
    check("events_left", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
